// File: rtl/button_debounce.sv
// Four-channel push-button debouncer: two-flop synchroniser, per-channel
// stability counter, registered debounced levels and one-cycle change pulses.
module button_debounce #(
    parameter int unsigned DEBOUNCE_COUNT = 500000,
    parameter int unsigned CNT_WIDTH      = 20
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic [3:0] BUTTONS_RAW,
    output logic [3:0] BUTTONS,
    output logic [3:0] EDGE
);

    localparam int unsigned N_BUTTONS = 4;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_COUNT - 1);

    logic [N_BUTTONS-1:0] sync1;
    logic [N_BUTTONS-1:0] sync2;
    logic [CNT_WIDTH-1:0] cnt [N_BUTTONS];
    logic [N_BUTTONS-1:0] mismatch_c;

    assign mismatch_c = sync2 ^ BUTTONS;

    // Raw inputs are asynchronous; nothing downstream looks at them before sync2.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= BUTTONS_RAW;
            sync2 <= sync1;
        end
    end

    // Each channel counts consecutive mismatch cycles and commits at CNT_MAX.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            BUTTONS <= '0;
            EDGE    <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            EDGE <= '0;
            for (int i = 0; i < N_BUTTONS; i++) begin
                if (!mismatch_c[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_MAX) begin
                    BUTTONS[i] <= sync2[i];
                    EDGE[i]    <= 1'b1;
                    cnt[i]     <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboarded bench for button_debounce with DEBOUNCE_COUNT=4, CNT_WIDTH=3.
module tb_button_debounce;

    localparam int unsigned DC = 4;
    localparam int unsigned CW = 3;

    logic       CLOCK = 1'b0;
    logic       RESET;
    logic [3:0] BUTTONS_RAW;
    logic [3:0] BUTTONS;
    logic [3:0] EDGE;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_q [$];

    // reference state: raw delayed by two edges, expected outputs, mismatch run lengths
    logic [3:0] raw_d1, raw_d2, exp_b, exp_e;
    int run [4];

    button_debounce #(.DEBOUNCE_COUNT(DC), .CNT_WIDTH(CW)) dut (
        .CLOCK(CLOCK),
        .RESET(RESET),
        .BUTTONS_RAW(BUTTONS_RAW),
        .BUTTONS(BUTTONS),
        .EDGE(EDGE)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
        end
    endtask

    // Output levels flip once the synchronised input has disagreed for DC edges in a row.
    task automatic model_step(input logic [3:0] raw, input logic rst);
        if (rst) begin
            raw_d1 = '0; raw_d2 = '0; exp_b = '0; exp_e = '0;
            for (int i = 0; i < 4; i++) run[i] = 0;
        end else begin
            exp_e = '0;
            for (int i = 0; i < 4; i++) begin
                if (raw_d2[i] != exp_b[i]) begin
                    run[i] = run[i] + 1;
                    if (run[i] == int'(DC)) begin
                        exp_b[i] = raw_d2[i];
                        exp_e[i] = 1'b1;
                        run[i]   = 0;
                    end
                end else begin
                    run[i] = 0;
                end
            end
            raw_d2 = raw_d1;
            raw_d1 = raw;
        end
    endtask

    task automatic tick(input logic [3:0] raw, input logic rst);
        logic [7:0] exp;
        BUTTONS_RAW = raw;
        RESET       = rst;
        model_step(raw, rst);
        sb_q.push_back({exp_b, exp_e});
        @(posedge CLOCK);
        #1;
        exp = sb_q.pop_front();
        check("sb", {BUTTONS, EDGE}, exp);
    endtask

    initial begin
        logic [3:0] r;
        RESET = 1'b1;
        BUTTONS_RAW = '0;

        // reset state
        tick(4'b0000, 1'b1);
        tick(4'b0000, 1'b1);
        check("rst_buttons", 8'(BUTTONS), 8'h00);
        check("rst_edge", 8'(EDGE), 8'h00);

        // single press on bit 0: change lands 5 edges after the first sampling edge
        for (int j = 0; j < 10; j++) begin
            tick(4'b0001, 1'b0);
            if (j == 4) check("press_early", 8'(BUTTONS), 8'h00);
            if (j == 5) begin
                check("press_btn", 8'(BUTTONS), 8'h01);
                check("press_edge", 8'(EDGE), 8'h01);
            end
            if (j == 6) check("press_edge_clr", 8'(EDGE), 8'h00);
        end

        // bit 2 bounces for 6 cycles then holds high
        for (int j = 0; j < 6; j++) begin
            tick((j % 2 == 0) ? 4'b0101 : 4'b0001, 1'b0);
            check("bounce_hold", 8'(BUTTONS), 8'h01);
        end
        for (int j = 0; j < 8; j++) begin
            tick(4'b0101, 1'b0);
            if (j == 4) check("bounce_early", 8'(BUTTONS), 8'h01);
            if (j == 5) begin
                check("bounce_btn", 8'(BUTTONS), 8'h05);
                check("bounce_edge", 8'(EDGE), 8'h04);
            end
        end

        // 3-cycle glitch on bit 3 is rejected
        for (int j = 0; j < 11; j++) begin
            tick((j < 3) ? 4'b1101 : 4'b0101, 1'b0);
            check("glitch_b3", 8'({BUTTONS[3], EDGE[3]}), 8'h00);
        end

        // all pressed, then simultaneous release
        for (int j = 0; j < 8; j++) tick(4'b1111, 1'b0);
        check("all_pressed", 8'(BUTTONS), 8'h0F);
        for (int j = 0; j < 8; j++) begin
            tick(4'b0000, 1'b0);
            if (j == 4) check("release_early", 8'(BUTTONS), 8'h0F);
            if (j == 5) begin
                check("release_btn", 8'(BUTTONS), 8'h00);
                check("release_edge", 8'(EDGE), 8'h0F);
            end
        end

        // reset mid-count on bit 0, then full re-debounce
        for (int j = 0; j < 4; j++) tick(4'b0001, 1'b0);
        tick(4'b0001, 1'b1);
        check("midrst_out", {BUTTONS, EDGE}, 8'h00);
        for (int j = 0; j < 8; j++) begin
            tick(4'b0001, 1'b0);
            if (j == 4) check("midrst_early", 8'(BUTTONS), 8'h00);
            if (j == 5) begin
                check("midrst_btn", 8'(BUTTONS), 8'h01);
                check("midrst_edge", 8'(EDGE), 8'h01);
            end
        end

        // independence: bit 0 press while bit 1 bounces every cycle
        tick(4'b0000, 1'b1);
        for (int j = 0; j < 10; j++) begin
            tick((j % 2 == 0) ? 4'b0011 : 4'b0001, 1'b0);
            if (j == 4) check("indep_early", 8'(BUTTONS), 8'h00);
            if (j == 5) begin
                check("indep_btn", 8'(BUTTONS), 8'h01);
                check("indep_edge", 8'(EDGE), 8'h01);
            end
        end
        check("indep_b1", 8'(BUTTONS[1]), 8'h00);

        // random activity with occasional long holds
        r = 4'b0000;
        for (int j = 0; j < 400; j++) begin
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            end
            tick(r, (j == 200) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_COUNT, default 500000, SHALL set the number of consecutive clock cycles a synchronised input must differ from its debounced output before the output changes; legal range 1 to 2^CNT_WIDTH-1.
REQ-002 Parameter CNT_WIDTH, default 20, SHALL set the per-channel counter width.
REQ-003 CLOCK  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-004 RESET  input  1  synchronous, active-high reset, sampled on the CLOCK rising edge.
REQ-005 BUTTONS_RAW  input  4  asynchronous, bouncing push-button levels, one bit per button.
REQ-006 BUTTONS  output  4  registered debounced levels; feeds the downstream button release detector's BUTTONS input.
REQ-007 EDGE  output  4  registered one-cycle pulse per bit, high in the cycle after the corresponding BUTTONS bit changes value.

Function
REQ-008 Each BUTTONS_RAW bit SHALL pass through a two-flop synchroniser (SYNC1, SYNC2) before any other logic uses it.
REQ-009 The four channels SHALL be fully independent and identical; activity on one bit SHALL NOT affect another.
REQ-010 Each channel SHALL hold a CNT_WIDTH-bit counter CNT[i].
REQ-011 Mismatch(i) SHALL mean SYNC2[i] differs from BUTTONS[i].
REQ-012 When Mismatch(i) is false at a clock edge, CNT[i] SHALL load 0.
REQ-013 When Mismatch(i) is true and CNT[i] is less than DEBOUNCE_COUNT-1, CNT[i] SHALL increment by 1.
REQ-014 When Mismatch(i) is true and CNT[i] equals DEBOUNCE_COUNT-1, BUTTONS[i] SHALL load SYNC2[i], CNT[i] SHALL load 0, and EDGE[i] SHALL be 1 for the following cycle.
REQ-015 EDGE[i] SHALL be 0 in every other cycle; back-to-back EDGE pulses on one bit SHALL be impossible unless DEBOUNCE_COUNT is 1.
REQ-016 Any mismatch run shorter than DEBOUNCE_COUNT consecutive cycles, i.e. a glitch or bounce, SHALL leave BUTTONS[i] unchanged and restart counting from 0.
REQ-017 Latency: for a raw level change set up before edge k and held, BUTTONS[i] SHALL change at edge k+1+DEBOUNCE_COUNT.
REQ-018 CNT[i] SHALL never exceed DEBOUNCE_COUNT-1, so no wrap-around occurs.
REQ-019 With DEBOUNCE_COUNT=1, BUTTONS SHALL follow SYNC2 with one cycle of delay.

Reset
REQ-020 RESET high at an edge SHALL clear SYNC1, SYNC2, all CNT, BUTTONS and EDGE to 0 on that edge; this overrides all other function.
REQ-021 RESET asserted mid-count SHALL discard the partial count; after release, counting SHALL restart from 0 against BUTTONS=0.
REQ-022 After RESET deasserts with BUTTONS_RAW held at 1, BUTTONS SHALL rise DEBOUNCE_COUNT+2 edges later with a single EDGE pulse.

Verification (DEBOUNCE_COUNT=4, CNT_WIDTH=3)
REQ-023 Reset, then BUTTONS_RAW=0001 set before edge k and held -> BUTTONS=0001 after edge k+5; EDGE=0001 for exactly one cycle after edge k+5; other bits stay 0.
REQ-024 Bit 2 bounces 1,0,1,0 each cycle for 6 cycles, then holds 1 -> no BUTTONS change during the bounce; BUTTONS[2]=1 exactly 5 edges after the final 0-to-1 transition.
REQ-025 Glitch: BUTTONS_RAW[3]=1 for 3 cycles, then 0 -> BUTTONS[3] and EDGE[3] stay 0 throughout.
REQ-026 Release: BUTTONS=1111 is stable, then BUTTONS_RAW=0000 is held -> all four bits fall at the same edge; EDGE=1111 for one cycle.
REQ-027 RESET pulsed for one cycle when CNT[0]=2 -> all outputs 0 on the next edge; the held input re-debounces taking the full 6 edges after RESET release.
REQ-028 Independence: bit 0 toggles and holds while bit 1 bounces -> bit 0 timing is identical to REQ-023 and unaffected by bit 1.
